// File: rtl/result_tx_pkg.sv
// Shared types for the result-record UART transmitter.
// RESULT_TX_PARITY_EN adds the ByteParity state (8E1 framing).
package result_tx_pkg;

  localparam int unsigned BYTES_PER_RECORD = 8;

  typedef struct packed {
    logic [15:0] addr;
    logic [47:0] value;
  } record_t;

  typedef enum logic [1:0] {
    RecIdle,
    RecLoad,
    RecSend,
    RecNext
  } rec_state_e;

  typedef enum logic [2:0] {
    ByteIdle,
    ByteStart,
    ByteData,
`ifdef RESULT_TX_PARITY_EN
    ByteParity,
`endif
    ByteStop
  } byte_state_e;

endpackage

// File: rtl/uart_byte_tx.sv
// Single-byte UART transmitter, LSB first, 8N1 or 8E1 when RESULT_TX_PARITY_EN is defined.
// The byte is latched at the end of the start bit, so the caller may update byte_in after start.
module uart_byte_tx
  import result_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] byte_in,
  output logic       tx,
  output logic       done
);

  localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);

  byte_state_e      state_q;
  logic [BaudW-1:0] baud_q;
  logic [2:0]       bit_q;
  logic [7:0]       shift_q;
  logic             tx_q;
  logic             baud_last;
`ifdef RESULT_TX_PARITY_EN
  logic             parity_q;
`endif

  assign baud_last = (baud_q == BaudLast);
  assign tx        = tx_q;
  assign done      = (state_q == ByteStop) && baud_last;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ByteIdle;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
`ifdef RESULT_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      if (state_q == ByteIdle || baud_last) begin
        baud_q <= '0;
      end else begin
        baud_q <= baud_q + 1'b1;
      end
      unique case (state_q)
        ByteIdle: begin
          if (start) begin
            state_q <= ByteStart;
            tx_q    <= 1'b0;
          end
        end
        ByteStart: begin
          if (baud_last) begin
            state_q  <= ByteData;
            tx_q     <= byte_in[0];
            shift_q  <= {1'b0, byte_in[7:1]};
            bit_q    <= '0;
`ifdef RESULT_TX_PARITY_EN
            parity_q <= ^byte_in;
`endif
          end
        end
        ByteData: begin
          if (baud_last) begin
            if (bit_q == 3'd7) begin
`ifdef RESULT_TX_PARITY_EN
              state_q <= ByteParity;
              tx_q    <= parity_q;
`else
              state_q <= ByteStop;
              tx_q    <= 1'b1;
`endif
            end else begin
              tx_q    <= shift_q[0];
              shift_q <= {1'b0, shift_q[7:1]};
              bit_q   <= bit_q + 1'b1;
            end
          end
        end
`ifdef RESULT_TX_PARITY_EN
        ByteParity: begin
          if (baud_last) begin
            state_q <= ByteStop;
            tx_q    <= 1'b1;
          end
        end
`endif
        ByteStop: begin
          if (baud_last) begin
            state_q <= ByteIdle;
          end
        end
        default: begin
          state_q <= ByteIdle;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/result_uart_tx.sv
// Buffers 64-bit {address, value} result records and streams them MSB byte first over UART.
// Define RESULT_TX_PARITY_EN for even-parity (8E1) framing.
module result_uart_tx
  import result_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [63:0]                 data,
  input  logic                        enable,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow
);

  localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
  localparam logic [2:0]  LastByte = 3'(BYTES_PER_RECORD - 1);

  record_t          mem_q [FIFO_DEPTH];
  logic [AddrW:0]   wr_ptr_q, rd_ptr_q;
  record_t          last_q;
  record_t          data_rec;
  logic             en_q;
  logic             overflow_q;
  logic             fifo_empty, fifo_full;
  logic             push_req, push, drop, pop;

  rec_state_e       state_q;
  logic [63:0]      shift_q;
  logic [2:0]       idx_q;
  logic             start_q;
  logic             active_q;
  logic             byte_done;

  assign data_rec   = data;
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                      (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
  assign pop        = (state_q == RecLoad);

  // A held record is pushed once; a new value under a held enable is a new record.
  assign push_req   = enable && (!en_q || (data_rec != last_q));
  assign push       = push_req && (!fifo_full || pop);
  assign drop       = push_req && fifo_full && !pop;

  assign fifo_count = wr_ptr_q - rd_ptr_q;
  assign overflow   = overflow_q;
  assign busy       = !fifo_empty || active_q;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AddrW-1:0]] <= data_rec;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_q       <= 1'b0;
      last_q     <= '0;
      wr_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      en_q <= enable;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
        last_q   <= data_rec;
      end
      if (drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // start_q is raised one cycle ahead so a byte begins straight out of LOAD or NEXT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= RecIdle;
      rd_ptr_q <= '0;
      shift_q  <= '0;
      idx_q    <= '0;
      start_q  <= 1'b0;
      active_q <= 1'b0;
    end else begin
      start_q <= 1'b0;
      unique case (state_q)
        RecIdle: begin
          if (!fifo_empty) begin
            state_q  <= RecLoad;
            start_q  <= 1'b1;
            active_q <= 1'b1;
          end
        end
        RecLoad: begin
          shift_q  <= mem_q[rd_ptr_q[AddrW-1:0]];
          rd_ptr_q <= rd_ptr_q + 1'b1;
          idx_q    <= '0;
          state_q  <= RecSend;
        end
        RecSend: begin
          if (byte_done) begin
            state_q <= RecNext;
            if (idx_q != LastByte) begin
              start_q <= 1'b1;
            end else begin
              active_q <= 1'b0;
            end
          end
        end
        RecNext: begin
          if (idx_q != LastByte) begin
            idx_q   <= idx_q + 1'b1;
            shift_q <= {shift_q[55:0], 8'h00};
            state_q <= RecSend;
          end else if (!fifo_empty) begin
            state_q  <= RecLoad;
            start_q  <= 1'b1;
            active_q <= 1'b1;
          end else begin
            state_q <= RecIdle;
          end
        end
        default: begin
          state_q  <= RecIdle;
          active_q <= 1'b0;
        end
      endcase
    end
  end

  uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_tx (
    .clk    (clk),
    .reset  (reset),
    .start  (start_q),
    .byte_in(shift_q[63:56]),
    .tx     (tx),
    .done   (byte_done)
  );

endmodule
